// File: rtl/kv_cmd_pkg.sv
// Shared definitions for the key-value command front end: FSM states, error codes,
// opcode assignments and the frame header layout.
package kv_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_WAIT_DONE,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_LENGTH  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] OP_REFER  = 8'd0;
  localparam logic [7:0] OP_ASSIGN = 8'd1;
  localparam logic [7:0] OP_DELETE = 8'd2;
  localparam logic [7:0] OP_QUERY  = 8'd3;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] len;
  } frame_hdr_t;

endpackage

// File: rtl/cmd_dispatcher_if.sv
// Host byte stream plus the one-hot payload bus toward the command units.
interface cmd_dispatcher_if #(
  parameter int unsigned NUM_CMDS = 4
);
  logic                in_valid;
  logic [7:0]          in_byte;
  logic                in_ready;
  logic [NUM_CMDS-1:0] cmd_sel;
  logic                cmd_valid;
  logic [7:0]          cmd_byte;
  logic                cmd_last;
  logic [NUM_CMDS-1:0] cmd_ready;
  logic [NUM_CMDS-1:0] cmd_done;

  // Dispatcher side
  modport slave (
    input  in_valid, in_byte, cmd_ready, cmd_done,
    output in_ready, cmd_sel, cmd_valid, cmd_byte, cmd_last
  );

  // Host receiver and command-unit side
  modport master (
    output in_valid, in_byte, cmd_ready, cmd_done,
    input  in_ready, cmd_sel, cmd_valid, cmd_byte, cmd_last
  );
endinterface

// File: rtl/cmd_stall_timer.sv
// Counts consecutive stall cycles while enabled; expired_c fires on the TIMEOUT-th one.
module cmd_stall_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired_c
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired_c = enable & ~clear & (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || clear || expired_c) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/cmd_dispatcher.sv
// Frame parser and one-hot dispatcher for the key-value command units.
// Optional stall abort enabled by defining CMD_TIMEOUT_EN.
module cmd_dispatcher
  import kv_cmd_pkg::*;
#(
  parameter int unsigned NUM_CMDS = 4,
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  cmd_dispatcher_if.slave  bus,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code
);
  localparam logic [NUM_CMDS-1:0] SEL_ONE = NUM_CMDS'(1);
  localparam logic                TMO_CFG = (TIMEOUT != 0);

  state_t              state;
  frame_hdr_t          hdr;
  logic [7:0]          cnt;
  logic [NUM_CMDS-1:0] sel;
  logic                run;
  logic                in_xfer;
  logic                sel_ready;
  logic                sel_done;
  logic                tmo;

  assign bus.cmd_sel = sel;
  assign sel_ready   = |(bus.cmd_ready & sel);
  assign sel_done    = |(bus.cmd_done & sel);
  assign in_xfer     = bus.in_valid & bus.in_ready;

  // Payload passes straight through; ready comes back from the selected unit
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = 8'd0;
    bus.cmd_last  = 1'b0;
    unique case (state)
      ST_IDLE:    bus.in_ready = run;
      ST_LEN:     bus.in_ready = 1'b1;
      ST_DRAIN:   bus.in_ready = 1'b1;
      ST_PAYLOAD: begin
        bus.in_ready  = sel_ready;
        bus.cmd_valid = bus.in_valid;
        bus.cmd_byte  = bus.in_byte;
        bus.cmd_last  = (cnt == 8'd1);
      end
      default: ;
    endcase
  end

`ifdef CMD_TIMEOUT_EN
  cmd_stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (state != ST_IDLE),
    .clear     (in_xfer | (|bus.cmd_done)),
    .expired_c (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  logic unused_cfg;
  assign unused_cfg = ^{TMO_CFG, hdr.len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hdr      <= '0;
      cnt      <= 8'd0;
      sel      <= '0;
      run      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      run <= 1'b1;
      err <= 1'b0;
      if (tmo) begin
        state    <= ST_IDLE;
        sel      <= '0;
        cnt      <= 8'd0;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (in_xfer) begin
              hdr.opcode <= bus.in_byte;
              state      <= ST_LEN;
              busy       <= 1'b1;
            end
          end
          ST_LEN: begin
            if (in_xfer) begin
              hdr.len <= bus.in_byte;
              if (hdr.opcode >= 8'(NUM_CMDS)) begin
                err      <= 1'b1;
                err_code <= ERR_OPCODE;
                if (bus.in_byte == 8'd0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end else begin
                  state <= ST_DRAIN;
                  cnt   <= bus.in_byte;
                end
              end else if (bus.in_byte > 8'(MAX_LEN)) begin
                err      <= 1'b1;
                err_code <= ERR_LENGTH;
                state    <= ST_DRAIN;
                cnt      <= bus.in_byte;
              end else begin
                sel <= SEL_ONE << hdr.opcode;
                if (bus.in_byte == 8'd0) begin
                  state <= ST_WAIT_DONE;
                end else begin
                  state <= ST_PAYLOAD;
                  cnt   <= bus.in_byte;
                end
              end
            end
          end
          ST_PAYLOAD: begin
            if (in_xfer) begin
              cnt <= cnt - 8'd1;
              if (cnt == 8'd1) state <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
            if (sel_done) begin
              state <= ST_IDLE;
              sel   <= '0;
              busy  <= 1'b0;
            end
          end
          ST_DRAIN: begin
            if (in_xfer) begin
              cnt <= cnt - 8'd1;
              if (cnt == 8'd1) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            sel   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher with a payload scoreboard and error-pulse monitor.
module tb_cmd_dispatcher;
  import kv_cmd_pkg::*;

  localparam int unsigned NUM_CMDS = 4;
  localparam int unsigned MAX_LEN  = 32;
  localparam int unsigned TIMEOUT  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  logic [8:0] exp_q[$];

  cmd_dispatcher_if #(.NUM_CMDS(NUM_CMDS)) bus ();

  cmd_dispatcher #(
    .NUM_CMDS (NUM_CMDS),
    .MAX_LEN  (MAX_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every byte accepted by the selected unit must match the next expected one
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sel_onehot0", 32'($onehot0(bus.cmd_sel)), 32'd1);
      if (bus.cmd_valid && |(bus.cmd_ready & bus.cmd_sel)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd_byte", {23'd0, bus.cmd_last, bus.cmd_byte}, 32'hFFFF_FFFF);
        end else begin
          chk("cmd_last_byte", {23'd0, bus.cmd_last, bus.cmd_byte}, {23'd0, exp_q.pop_front()});
        end
      end
      if (err) err_seen++;
    end
  end

  // Present one host byte and hold it until accepted; returns #1 after the transfer edge
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_done(input int idx);
    bus.cmd_done[idx] = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_done = '0;
  endtask

  task automatic push(input logic last, input logic [7:0] b);
    exp_q.push_back({last, b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'd0;
    bus.cmd_ready = '0;
    bus.cmd_done  = '0;

    #2 rst_n = 1'b0;
    #20;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_cmd_sel", 32'(bus.cmd_sel), 32'd0);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.cmd_ready = 4'b1111;

    // Basic frame to unit 0
    push(0, 8'hAA); push(0, 8'hBB); push(1, 8'hCC);
    send(OP_REFER);
    chk("len_busy", 32'(busy), 32'd1);
    send(8'd3);
    chk("t1_sel", 32'(bus.cmd_sel), 32'b0001);
    send(8'hAA); send(8'hBB); send(8'hCC);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_wait_busy", 32'(busy), 32'd1);
    chk("t1_wait_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_wait_valid", 32'(bus.cmd_valid), 32'd0);
    chk("t1_wait_sel", 32'(bus.cmd_sel), 32'b0001);
    pulse_done(0);
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_done_sel", 32'(bus.cmd_sel), 32'd0);

    // Same frame with unit 0 stalling two cycles on BB
    push(0, 8'hAA); push(0, 8'hBB); push(1, 8'hCC);
    send(OP_REFER); send(8'd3); send(8'hAA);
    bus.cmd_ready[0] = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hBB;
    @(negedge clk);
    chk("t2_stall_ready1", 32'(bus.in_ready), 32'd0);
    chk("t2_stall_valid", 32'(bus.cmd_valid), 32'd1);
    @(negedge clk);
    chk("t2_stall_ready2", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.cmd_ready[0] = 1'b1;
    send(8'hBB); send(8'hCC);
    pulse_done(0);
    chk("t2_idle", 32'(busy), 32'd0);

    // Bad opcode with payload is drained
    e0 = err_seen;
    send(8'h07); send(8'h02);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_code", 32'(err_code), 32'(ERR_OPCODE));
    chk("t3_sel", 32'(bus.cmd_sel), 32'd0);
    send(8'h11);
    chk("t3_err_pulse", 32'(err), 32'd0);
    send(8'h22);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_err_count", 32'(err_seen - e0), 32'd1);

    // Oversize length is drained
    send(OP_ASSIGN); send(8'h40);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_code", 32'(err_code), 32'(ERR_LENGTH));
    for (int i = 0; i < 64; i++) send(8'(i));
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_sel", 32'(bus.cmd_sel), 32'd0);

    // Length exactly MAX_LEN is accepted
    for (int i = 0; i < 32; i++) push(i == 31, 8'(8'h80 + i));
    send(OP_ASSIGN); send(8'd32);
    chk("t5_sel", 32'(bus.cmd_sel), 32'b0010);
    for (int i = 0; i < 32; i++) send(8'(8'h80 + i));
    chk("t5_wait", 32'(busy), 32'd1);
    pulse_done(1);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_code_held", 32'(err_code), 32'(ERR_LENGTH));

    // Zero-payload command; done from other unit ignored
    send(OP_DELETE); send(8'd0);
    chk("t6_sel", 32'(bus.cmd_sel), 32'b0100);
    chk("t6_valid", 32'(bus.cmd_valid), 32'd0);
    pulse_done(1);
    chk("t6_ignored_busy", 32'(busy), 32'd1);
    chk("t6_ignored_sel", 32'(bus.cmd_sel), 32'b0100);
    pulse_done(2);
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_sel_clr", 32'(bus.cmd_sel), 32'd0);

    // Highest opcode; done coincident with the last payload transfer is ignored
    push(1, 8'h5A);
    send(OP_QUERY); send(8'd1);
    chk("t7_sel", 32'(bus.cmd_sel), 32'b1000);
    bus.cmd_done[3] = 1'b1;
    send(8'h5A);
    bus.cmd_done = '0;
    chk("t7_still_busy", 32'(busy), 32'd1);
    pulse_done(3);
    chk("t7_idle", 32'(busy), 32'd0);

    // Bad opcode NUM_CMDS with zero length goes straight back to idle
    send(8'd4); send(8'd0);
    chk("t8_err", 32'(err), 32'd1);
    chk("t8_code", 32'(err_code), 32'(ERR_OPCODE));
    chk("t8_idle", 32'(busy), 32'd0);

    // Reset in the middle of a payload
    push(0, 8'hAA);
    send(OP_REFER); send(8'd3); send(8'hAA);
    rst_n = 1'b0;
    #1;
    chk("t9_sel", 32'(bus.cmd_sel), 32'd0);
    chk("t9_busy", 32'(busy), 32'd0);
    chk("t9_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t9_valid", 32'(bus.cmd_valid), 32'd0);
    chk("t9_code", 32'(err_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(1, 8'h77);
    send(OP_ASSIGN); send(8'd1); send(8'h77);
    pulse_done(1);
    chk("t9_recover_idle", 32'(busy), 32'd0);

`ifdef CMD_TIMEOUT_EN
    // No done: abort after TIMEOUT stall cycles
    send(OP_DELETE); send(8'd0);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("t10_no_err_yet", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    chk("t10_err", 32'(err), 32'd1);
    chk("t10_code", 32'(err_code), 32'(ERR_TIMEOUT));
    chk("t10_idle", 32'(busy), 32'd0);
    chk("t10_sel", 32'(bus.cmd_sel), 32'd0);
`endif

    @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
